stream_upsizer: RTL and testbench

//  Packs a narrow valid/ready stream into words RATIO times wider. RATIO is any integer >= 1,
//  not restricted to powers of two, so no cascade of 2:1 stages is needed.

---
 rtl/adapter_pkg.sv | 13 +
 rtl/stream_upsizer_if.sv | 28 ++
 rtl/stream_reg_slice.sv | 28 ++
 rtl/stream_upsizer.sv | 64 ++++++
 tb/tb_stream_upsizer.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/adapter_pkg.sv
// adapter_pkg: helpers shared by the stream width adapters (upsizer/downsizer)
package adapter_pkg;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Physical lane slot of logical lane k; MSB_FIRST mirrors the order
    function automatic int lane_pos(input int k, input int ratio, input bit msb_first);
        return msb_first ? ratio - 1 - k : k;
    endfunction

endpackage

// File: rtl/stream_upsizer_if.sv
// stream_upsizer_if: narrow input stream and wide packed output stream of the upsizer
interface stream_upsizer_if #(
    parameter int DIN_W = 16,
    parameter int RATIO = 8
);
    localparam int DOUT_W = DIN_W * RATIO;

    logic              din_vld;
    logic              din_rdy;
    logic              din_last;
    logic [DIN_W-1:0]  din;
    logic              dout_vld;
    logic              dout_rdy;
    logic              dout_last;
    logic [DOUT_W-1:0] dout;
    logic [RATIO-1:0]  dout_keep;

    modport master (
        output din_vld, din_last, din, dout_rdy,
        input  din_rdy, dout_vld, dout_last, dout, dout_keep
    );

    modport slave (
        input  din_vld, din_last, din, dout_rdy,
        output din_rdy, dout_vld, dout_last, dout, dout_keep
    );

endinterface

// File: rtl/stream_reg_slice.sv
// stream_reg_slice: one-entry valid/ready register; holds while stalled, replaces on drain+load
module stream_reg_slice #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_data
);

    assign in_rdy = ~out_vld | out_rdy;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_vld  <= 1'b0;
            out_data <= '0;
        end else if (in_rdy) begin
            out_vld <= in_vld;
            if (in_vld)
                out_data <= in_data;
        end
    end

endmodule

// File: rtl/stream_upsizer.sv
// stream_upsizer: packs RATIO narrow beats into one wide word, flushing short words on last
module stream_upsizer
    import adapter_pkg::*;
#(
    parameter int DIN_W     = 16,
    parameter int RATIO     = 8,
    parameter int MSB_FIRST = 0
) (
    input logic             clk,
    input logic             rstn,
    stream_upsizer_if.slave s
);

    localparam int DOUT_W = DIN_W * RATIO;
    localparam int CW     = clog2_min1(RATIO);

    logic [CW-1:0]     cnt;
    logic [DOUT_W-1:0] acc;
    logic [DOUT_W-1:0] word;
    logic [RATIO-1:0]  keep;
    logic [RATIO-1:0]  keep_nxt;
    logic              take;
    logic              done;

    assign take = s.din_vld & s.din_rdy;
    assign done = (cnt == CW'(RATIO - 1)) | s.din_last;

    // Accumulator with the current beat merged in; becomes the output word on a completing beat
    always_comb begin
        word     = acc;
        keep_nxt = keep;
        for (int k = 0; k < RATIO; k++)
            if (cnt == CW'(k)) begin
                word[lane_pos(k, RATIO, MSB_FIRST != 0)*DIN_W +: DIN_W] = s.din;
                keep_nxt[lane_pos(k, RATIO, MSB_FIRST != 0)]            = 1'b1;
            end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt  <= '0;
            acc  <= '0;
            keep <= '0;
        end else if (take) begin
            cnt  <= done ? '0 : cnt + CW'(1);
            acc  <= done ? '0 : word;
            keep <= done ? '0 : keep_nxt;
        end
    end

    stream_reg_slice #(
        .WIDTH(DOUT_W + RATIO + 1)
    ) u_out (
        .clk     (clk),
        .rstn    (rstn),
        .in_vld  (s.din_vld & done),
        .in_rdy  (s.din_rdy),
        .in_data ({s.din_last, keep_nxt, word}),
        .out_vld (s.dout_vld),
        .out_rdy (s.dout_rdy),
        .out_data({s.dout_last, s.dout_keep, s.dout})
    );

endmodule

// File: tb/tb_stream_upsizer.sv
// tb_stream_upsizer: queue-based packing model checked every cycle, plus literal word checks
module tb_stream_upsizer;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    stream_upsizer_if #(.DIN_W(16), .RATIO(8)) ia ();
    stream_upsizer_if #(.DIN_W(16), .RATIO(3)) ib ();

    stream_upsizer #(.DIN_W(16), .RATIO(8), .MSB_FIRST(0)) u_a (.clk(clk), .rstn(rstn), .s(ia));
    stream_upsizer #(.DIN_W(16), .RATIO(3), .MSB_FIRST(1)) u_b (.clk(clk), .rstn(rstn), .s(ib));

    typedef struct {
        logic [127:0] d;
        logic [7:0]   k;
        logic         l;
    } word_t;

    word_t        qa[$];
    word_t        qb[$];
    logic [15:0]  pa[$];
    logic [15:0]  pb[$];
    logic [127:0] got_a_d, got_b_d;
    logic [7:0]   got_a_k, got_b_k;
    logic         got_a_l, got_b_l;
    logic         ra, rb;
    bit           rnd_on;

    task automatic chk(input string n, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, got, exp);
        end
    endtask

    // Logical beat i sits in slot i, or slot ratio-1-i when mirrored; untouched slots stay zero
    function automatic word_t pack(input logic [15:0] beats[$], input int ratio, input bit msb,
                                   input logic last);
        word_t w;
        w.d = '0;
        w.k = '0;
        w.l = last;
        foreach (beats[i]) begin
            int p;
            p = msb ? ratio - 1 - i : i;
            w.d[p*16 +: 16] = beats[i];
            w.k[p]          = 1'b1;
        end
        return w;
    endfunction

    always @(negedge clk) begin
        if (!rstn) begin
            qa.delete();
            pa.delete();
        end else begin
            ra = (qa.size() == 0) || ia.dout_rdy;
            chk("a_vld", ia.dout_vld, qa.size() != 0);
            chk("a_din_rdy", ia.din_rdy, ra);
            if (qa.size() != 0) begin
                chk("a_dout", ia.dout, qa[0].d);
                chk("a_keep", ia.dout_keep, qa[0].k);
                chk("a_last", ia.dout_last, qa[0].l);
                if (ia.dout_rdy) begin
                    got_a_d = ia.dout;
                    got_a_k = ia.dout_keep;
                    got_a_l = ia.dout_last;
                    void'(qa.pop_front());
                end
            end
            if (ia.din_vld && ra) begin
                pa.push_back(ia.din);
                if (pa.size() == 8 || ia.din_last) begin
                    qa.push_back(pack(pa, 8, 1'b0, ia.din_last));
                    pa.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rstn) begin
            qb.delete();
            pb.delete();
        end else begin
            rb = (qb.size() == 0) || ib.dout_rdy;
            chk("b_vld", ib.dout_vld, qb.size() != 0);
            chk("b_din_rdy", ib.din_rdy, rb);
            if (qb.size() != 0) begin
                chk("b_dout", ib.dout, qb[0].d);
                chk("b_keep", ib.dout_keep, qb[0].k);
                chk("b_last", ib.dout_last, qb[0].l);
                if (ib.dout_rdy) begin
                    got_b_d = ib.dout;
                    got_b_k = ib.dout_keep;
                    got_b_l = ib.dout_last;
                    void'(qb.pop_front());
                end
            end
            if (ib.din_vld && rb) begin
                pb.push_back(ib.din);
                if (pb.size() == 3 || ib.din_last) begin
                    qb.push_back(pack(pb, 3, 1'b1, ib.din_last));
                    pb.delete();
                end
            end
        end
    end

    task automatic send_a(input logic [15:0] v, input logic l);
        int n = 0;
        ia.din_vld  = 1'b1;
        ia.din      = v;
        ia.din_last = l;
        @(negedge clk);
        while (!ia.din_rdy && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL a_send: din_rdy stuck low for %0d cycles, want accept", n);
        end
        @(posedge clk);
        #1 ia.din_vld = 1'b0;
    endtask

    task automatic send_b(input logic [15:0] v, input logic l);
        int n = 0;
        ib.din_vld  = 1'b1;
        ib.din      = v;
        ib.din_last = l;
        @(negedge clk);
        while (!ib.din_rdy && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL b_send: din_rdy stuck low for %0d cycles, want accept", n);
        end
        @(posedge clk);
        #1 ib.din_vld = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        ia.din_vld = 0; ia.din_last = 0; ia.din = '0; ia.dout_rdy = 1;
        ib.din_vld = 0; ib.din_last = 0; ib.din = '0; ib.dout_rdy = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vld", ia.dout_vld, 0);
        chk("rst_dout", ia.dout, 0);
        chk("rst_keep", ia.dout_keep, 0);
        chk("rst_din_rdy", ia.din_rdy, 1);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) send_a(16'(i), i == 7);
        settle();
        chk("t1_dout", got_a_d, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
        chk("t1_keep", got_a_k, 8'hFF);
        chk("t1_last", got_a_l, 1);

        send_a(16'h11, 0); send_a(16'h22, 0); send_a(16'h33, 1);
        settle();
        chk("t3_dout", got_a_d, 128'h0033_0022_0011);
        chk("t3_keep", got_a_k, 8'h07);
        chk("t3_last", got_a_l, 1);

        send_b(16'hA, 0); send_b(16'hB, 0); send_b(16'hC, 0);
        settle();
        chk("t2_dout", got_b_d, 128'h000A_000B_000C);
        chk("t2_keep", got_b_k, 3'b111);
        chk("t2_last", got_b_l, 0);
        send_b(16'h1, 0); send_b(16'h2, 1);
        settle();
        chk("t5_dout", got_b_d, 128'h0001_0002_0000);
        chk("t5_keep", got_b_k, 3'b110);
        chk("t5_last", got_b_l, 1);

        ia.dout_rdy = 1'b0;
        fork
            for (int i = 0; i < 30; i++) send_a(16'($urandom), 0);
            begin
                repeat (20) @(posedge clk);
                @(negedge clk);
                chk("stall_din_rdy", ia.din_rdy, 0);
                chk("stall_vld", ia.dout_vld, 1);
                @(posedge clk);
                #1 ia.dout_rdy = 1'b1;
            end
        join
        t0 = cyc;
        for (int i = 0; i < 16; i++) send_a(16'($urandom), 0);
        chk("throughput_cycles", cyc - t0, 16);
        send_a(16'hBEEF, 1);

        for (int i = 0; i < 5; i++) send_a(16'h100 + 16'(i), 0);
        #2 rstn = 1'b0;
        #1;
        chk("arst_vld", ia.dout_vld, 0);
        chk("arst_dout", ia.dout, 0);
        chk("arst_keep", ia.dout_keep, 0);
        chk("arst_last", ia.dout_last, 0);
        @(negedge clk);
        @(posedge clk);
        #3 rstn = 1'b1;
        @(posedge clk);
        #1;
        send_a(16'h11, 0); send_a(16'h22, 0); send_a(16'h33, 1);
        settle();
        chk("arst_t3_dout", got_a_d, 128'h0033_0022_0011);
        chk("arst_t3_keep", got_a_k, 8'h07);

        rnd_on = 1'b1;
        fork
            while (rnd_on) begin
                @(posedge clk);
                #1;
                ia.dout_rdy = $urandom_range(0, 3) != 0;
                ib.dout_rdy = $urandom_range(0, 2) != 0;
            end
        join_none
        fork
            for (int i = 0; i < 300; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                send_a(16'($urandom), $urandom_range(0, 7) == 0);
            end
            for (int i = 0; i < 200; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                send_b(16'($urandom), $urandom_range(0, 4) == 0);
            end
        join
        rnd_on = 1'b0;
        @(posedge clk);
        #1;
        ia.dout_rdy = 1'b1;
        ib.dout_rdy = 1'b1;
        send_a(16'h0, 1);
        send_b(16'h0, 1);
        repeat (5) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
